// File: rtl/reg_hazard_scoreboard_pkg.sv
// reg_hazard_scoreboard_pkg: shared widths and the pending-write slot type
package reg_hazard_scoreboard_pkg;
    localparam int REG_W       = 3;
    localparam int NREGS       = 8;
    localparam int STALL_CNT_W = 16;

    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] rd;
    } slot_t;
endpackage

// File: rtl/reg_hazard_scoreboard_hazard_match.sv
// hazard_match: flags a used source register that matches any pending slot write
module hazard_match
    import reg_hazard_scoreboard_pkg::*;
#(
    parameter int DEPTH     = 3,
    parameter bit RF_BYPASS = 1'b1
) (
    input  slot_t [DEPTH-1:0] slots_i,
    input  logic [REG_W-1:0]  src_i,
    input  logic              used_i,
    output logic              hit_o
);
    // a retiring-slot match is harmless when the register file writes before it reads
    always_comb begin
        hit_o = 1'b0;
        for (int k = 0; k < DEPTH; k++)
            hit_o = hit_o | (used_i & slots_i[k].v & (slots_i[k].rd == src_i)
                             & ~(RF_BYPASS & (k == DEPTH - 1)));
    end
endmodule

// File: rtl/reg_hazard_scoreboard.sv
// reg_hazard_scoreboard: in-flight destination tracker producing the decode RAW stall
module reg_hazard_scoreboard
    import reg_hazard_scoreboard_pkg::*;
#(
    parameter int DEPTH     = 3,
    parameter bit RF_BYPASS = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic                   id_we,
    input  logic [REG_W-1:0]       id_rd,
    input  logic [REG_W-1:0]       id_rs,
    input  logic [REG_W-1:0]       id_rt,
    input  logic                   id_rs_used,
    input  logic                   id_rt_used,
    input  logic                   freeze,
    input  logic [DEPTH-1:0]       flush,
    output logic                   stall,
    output logic                   wb_valid,
    output logic [REG_W-1:0]       wb_rd,
    output logic [NREGS-1:0]       busy_mask,
    output logic [STALL_CNT_W-1:0] stall_cnt
);
    slot_t [DEPTH-1:0]      slots_q, slots_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic                   rs_hit, rt_hit, issue;

    hazard_match #(.DEPTH(DEPTH), .RF_BYPASS(RF_BYPASS)) u_rs (
        .slots_i(slots_q), .src_i(id_rs), .used_i(id_rs_used), .hit_o(rs_hit)
    );
    hazard_match #(.DEPTH(DEPTH), .RF_BYPASS(RF_BYPASS)) u_rt (
        .slots_i(slots_q), .src_i(id_rt), .used_i(id_rt_used), .hit_o(rt_hit)
    );

    assign stall     = id_valid & (rs_hit | rt_hit) & ~freeze;
    assign issue     = id_valid & ~stall & ~freeze;
    assign wb_valid  = slots_q[DEPTH-1].v;
    assign wb_rd     = slots_q[DEPTH-1].rd;
    assign stall_cnt = stall_cnt_q;

    // shift (or hold under freeze), then apply the per-slot kill mask
    always_comb begin
        slots_d = slots_q;
        if (!freeze) begin
            slots_d[0] = '{v: issue & id_we, rd: id_rd};
            for (int k = 1; k < DEPTH; k++)
                slots_d[k] = slots_q[k-1];
        end
        for (int k = 0; k < DEPTH; k++)
            if (flush[k])
                slots_d[k].v = 1'b0;
        stall_cnt_d = (stall && stall_cnt_q != '1) ? stall_cnt_q + STALL_CNT_W'(1) : stall_cnt_q;
    end

    // one-hot OR of every valid pending destination
    always_comb begin
        busy_mask = '0;
        for (int k = 0; k < DEPTH; k++)
            if (slots_q[k].v)
                busy_mask[slots_q[k].rd] = 1'b1;
    end

    // slot array and stall counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            slots_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            slots_q     <= slots_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
endmodule

// File: tb/tb_reg_hazard_scoreboard.sv
// tb_reg_hazard_scoreboard: directed and random checks against an in-flight instruction list model
module tb_reg_hazard_scoreboard;
    localparam int D   = 3;
    localparam bit BYP = 1'b1;

    logic         clk = 1'b0;
    logic         rst, id_valid, id_we, id_rs_used, id_rt_used, freeze;
    logic [2:0]   id_rd, id_rs, id_rt;
    logic [D-1:0] flush;
    logic         stall, wb_valid;
    logic [2:0]   wb_rd;
    logic [7:0]   busy_mask;
    logic [15:0]  stall_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int rd;
        int stage;
    } ent_t;
    ent_t q[$];
    int   mcnt;

    always #5 clk = ~clk;

    reg_hazard_scoreboard #(.DEPTH(D), .RF_BYPASS(BYP)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_we(id_we), .id_rd(id_rd),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .freeze(freeze), .flush(flush), .stall(stall), .wb_valid(wb_valid),
        .wb_rd(wb_rd), .busy_mask(busy_mask), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_hz(input int s, input bit used);
        m_hz = 1'b0;
        foreach (q[i])
            if (used && q[i].rd == s && !(BYP && q[i].stage == D - 1))
                m_hz = 1'b1;
    endfunction

    function automatic bit m_stall();
        return id_valid && !freeze && (m_hz(int'(id_rs), id_rs_used) || m_hz(int'(id_rt), id_rt_used));
    endfunction

    task automatic drive(input bit v, input bit we, input int rd, input int rs, input bit rsu,
                         input int rt, input bit rtu);
        id_valid = v; id_we = we; id_rd = 3'(rd);
        id_rs = 3'(rs); id_rs_used = rsu; id_rt = 3'(rt); id_rt_used = rtu;
    endtask

    task automatic cyc();
        bit     ms, mwb;
        int     mwbrd;
        logic [7:0] mb;
        ent_t   nq[$];
        @(negedge clk);
        ms = m_stall();
        mb = '0; mwb = 1'b0; mwbrd = 0;
        foreach (q[i]) begin
            mb[q[i].rd] = 1'b1;
            if (q[i].stage == D - 1) begin mwb = 1'b1; mwbrd = q[i].rd; end
        end
        chk("stall", 32'(stall), 32'(ms));
        chk("busy_mask", 32'(busy_mask), 32'(mb));
        chk("wb_valid", 32'(wb_valid), 32'(mwb));
        if (mwb) chk("wb_rd", 32'(wb_rd), 32'(mwbrd));
        chk("stall_cnt", 32'(stall_cnt), 32'(mcnt));
        if (rst) begin
            q.delete();
            mcnt = 0;
        end else begin
            foreach (q[i]) begin
                ent_t e = q[i];
                if (!freeze) e.stage++;
                if (e.stage < D && !flush[e.stage]) nq.push_back(e);
            end
            if (!freeze && id_valid && !ms && id_we && !flush[0])
                nq.push_back('{rd: int'(id_rd), stage: 0});
            q = nq;
            if (ms && mcnt < 65535) mcnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (n) cyc();
    endtask

    initial begin
        int c0;
        rst = 1'b1; freeze = 1'b0; flush = '0;
        drive(1, 1, 3, 3, 1, 3, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_wb_valid", 32'(wb_valid), 0);
        chk("rst_wb_rd", 32'(wb_rd), 0);
        chk("rst_busy", 32'(busy_mask), 0);
        chk("rst_cnt", 32'(stall_cnt), 0);
        q.delete(); mcnt = 0;
        @(posedge clk); #1;
        rst = 1'b0;

        drive(1, 1, 3, 0, 0, 0, 0); cyc();
        drive(1, 1, 4, 3, 1, 0, 0);
        repeat (3) cyc();
        chk("raw_cnt", 32'(stall_cnt), 2);
        idle(3);

        drive(1, 1, 1, 0, 0, 0, 0); cyc(); chk("indep_busy1", 32'(busy_mask), 8'h02);
        drive(1, 1, 2, 0, 0, 0, 0); cyc(); chk("indep_busy2", 32'(busy_mask), 8'h06);
        drive(1, 1, 4, 0, 0, 0, 0); cyc(); chk("indep_busy3", 32'(busy_mask), 8'h16);
        chk("indep_wb_valid", 32'(wb_valid), 1);
        chk("indep_wb_rd", 32'(wb_rd), 1);
        drive(1, 0, 0, 5, 1, 5, 1); cyc();
        idle(3);

        drive(1, 1, 6, 0, 0, 0, 0); cyc();
        drive(1, 0, 0, 0, 0, 6, 1); cyc();
        c0 = int'(stall_cnt);
        freeze = 1'b1;
        repeat (4) cyc();
        chk("frz_cnt_held", 32'(stall_cnt), 32'(c0));
        chk("frz_busy_held", 32'(busy_mask), 8'h40);
        freeze = 1'b0;
        repeat (4) cyc();
        chk("frz_remainder", 32'(int'(stall_cnt) - c0), 1);
        idle(3);

        drive(1, 1, 2, 0, 0, 0, 0); flush = 3'b001; cyc(); flush = '0;
        drive(1, 0, 0, 2, 1, 0, 0); cyc();
        chk("flush0_busy2", 32'(busy_mask[2]), 0);
        drive(1, 1, 2, 0, 0, 0, 0); cyc();
        drive(1, 0, 0, 2, 1, 0, 0); flush = 3'b010; cyc(); flush = '0;
        cyc();
        chk("flush1_busy2", 32'(busy_mask[2]), 0);
        idle(3);

        drive(1, 0, 5, 0, 0, 0, 0); cyc();
        drive(1, 0, 0, 5, 1, 5, 1); cyc();
        drive(1, 1, 7, 0, 0, 0, 0); cyc();
        drive(1, 0, 0, 0, 1, 7, 0); cyc();
        chk("unused_cnt", 32'(stall_cnt), 32'(mcnt));
        idle(3);

        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1));
            freeze = $urandom_range(0, 9) == 0;
            flush  = ($urandom_range(0, 9) == 0) ? D'($urandom_range(1, (1 << D) - 1)) : '0;
            rst    = $urandom_range(0, 49) == 0;
            cyc();
        end
        rst = 1'b0; freeze = 1'b0; flush = '0;
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/reg_hazard_scoreboard.md
# reg_hazard_scoreboard

Tracks in-flight register writes between decode and writeback in the 16-bit, 8-register pipelined core and produces the decode-stage stall for read-after-write hazards. The decode stage presents each instruction's destination, as selected by the ALU destination decode (register-format `instr[4:2]`, immediate-format `instr[7:5]`, LBI/SLBI `instr[10:8]`), together with its source registers. The block holds a shift register of pending destinations, one slot per pipeline stage after decode. It also provides the writeback-retire view and a stall performance counter.

## Interface
Parameters:
- `DEPTH`, 3: number of stages from decode exit to register-file write (ID/EX, EX/MEM, MEM/WB); legal range 1–6.
- `RF_BYPASS`, 1: when 1, the register file is write-before-read, so a source matching only the retiring slot is not a hazard.

Ports:
- `clk` in 1: clock. Single clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `id_valid` in 1: decode holds a real instruction.
- `id_we` in 1: the instruction writes a register (0 for branches, J, JR, ST, NOP, HALT, SIIC, RTI).
- `id_rd` in 3: destination register.
- `id_rs`, `id_rt` in 3 each: source registers.
- `id_rs_used`, `id_rt_used` in 1 each: the corresponding source is actually read.
- `freeze` in 1: whole pipeline is held (memory stall).
- `flush` in DEPTH: per-slot kill mask; bit k kills slot k.
- `stall` out 1: decode must hold and insert a bubble.
- `wb_valid` out 1: slot DEPTH-1 holds a valid pending write this cycle.
- `wb_rd` out 3: register number of that pending write.
- `busy_mask` out 8: bit r set if any valid slot targets register r.
- `stall_cnt` out 16: saturating count of stall cycles.

## Operation
- State: `DEPTH` slots, each holding {v, rd}. Slot 0 is the youngest (ID/EX); slot DEPTH-1 is retiring at WB.
- Hazard on a source s: s is used, and some slot k has v=1 with rd=s. With `RF_BYPASS`=1, a match only at k=DEPTH-1 does not count as a hazard.
- `stall` = `id_valid` & (rs hazard | rt hazard) & ~`freeze`.
- Issue = `id_valid` & ~`stall` & ~`freeze`. Slot 0 receives {`id_we`, `id_rd`} on issue; otherwise it receives {0, x}, which is a bubble.
- Normal cycle (`freeze`=0): slot k+1 takes the old slot k, and slot 0 takes the issue or bubble. The old slot DEPTH-1 retires.
- `freeze`=1: slots hold their values. No issue, no retire. `stall` is 0, because `freeze` already holds decode.
- `flush`: applied after the shift/hold step. For every set bit k, the slot's next v becomes 0. `flush`[0] also kills the instruction being issued this cycle. `flush` takes effect even during `freeze`.
- Register 0 is an ordinary register; there is no hardwired zero.
- `wb_valid`/`wb_rd` are driven directly from slot DEPTH-1. `busy_mask` is the OR over valid slots of one-hot(rd).
- `stall_cnt` increments on each cycle with `stall`=1 and saturates at 16'hFFFF.
- Reset: all v=0, `stall_cnt`=0. Consequently `stall`=0, `wb_valid`=0, `wb_rd`=0 and `busy_mask`=0. Reset overrides `freeze` and `flush`. A reset asserted mid-stall discards all pending entries.

## Timing
- `stall` is combinational from registered slots and same-cycle `id_*` inputs, with zero latency. It must settle well inside the decode cycle.
- An instruction issued at cycle t occupies slot k during cycle t+1+k, excluding frozen cycles, and retires at the end of cycle t+DEPTH.
- With `RF_BYPASS`=1, a dependent instruction directly behind a producer stalls DEPTH-1 cycles. With `RF_BYPASS`=0 it stalls DEPTH cycles.
- `stall_cnt`, slots and `busy_mask` update on the `clk` rising edge. `busy_mask` reflects registered state only.

## Structure
- Shared package: `REG_W`=3, `NREGS`=8, the `slot_t` {v, rd} struct, and `STALL_CNT_W`=16.
- Sub-module `hazard_match`: compares one source register against all slots and applies the `RF_BYPASS` mask. The top level instantiates it twice, once for rs and once for rt.
- Slots are a flat register array; no memory macro is used.

## Test plan
- Reset: hold `rst` for 2 cycles while driving `id_valid`=1 → `stall`=0, `wb_valid`=0, `busy_mask`=0, `stall_cnt`=0.
- Back-to-back RAW with DEPTH=3, `RF_BYPASS`=1: ADD writing r3, then next cycle SUB reading rs=r3 → `stall`=1 for exactly 2 cycles. SUB issues on the third cycle, and `stall_cnt`=2.
- Independent instructions: issue writes to r1, r2, r4, then a read of r5 → no stall. `busy_mask` sequence 0x02, 0x06, 0x16, then `wb_valid`=1 with `wb_rd`=1.
- `freeze` mid-hazard: producer writes r6, consumer waits, `freeze` held 4 cycles → slots unchanged and `stall`=0 during freeze. After release, the remaining stall count equals the pre-freeze remainder.
- Flush: r2 pending in slot 0, consumer reads r2, `flush`=3'b001 → the next cycle has no stall, and `busy_mask` bit 2 is clear.
- Non-writer and unused sources: BEQZ with `id_we`=0 followed by a read of its rd field → no stall. A source matching a pending write but with `id_rt_used`=0 → no stall.
